// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - shared types and Q1.15 constants for the chaotic keystream blocks
package chaos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [15:0] ONE_Q15         = 16'h7FFF;
    localparam logic [15:0] DEFAULT_SEED    = 16'h7EF0;
    localparam logic [15:0] PERTURB_DEFAULT = 16'h5A5A;

endpackage

// File: rtl/quadratic_step.sv
// rtl/quadratic_step.sv - one iteration of x' = 0x7FFF - ((x*x) <<< 1)[30:15] in Q1.15
module quadratic_step
    import chaos_pkg::*;
(
    input  logic [15:0] x,
    output logic [15:0] x_next
);

    logic signed [31:0] xs;
    logic signed [31:0] sq;

    assign xs = 32'($signed(x));
    assign sq = xs * xs;
    // (sq <<< 1)[30:15] is the same slice as sq[29:14]; the subtraction wraps mod 2^16
    assign x_next = ONE_Q15 - 16'(sq >>> 14);

endmodule

// File: rtl/chaos_keystream_ctrl.sv
// rtl/chaos_keystream_ctrl.sv - seed/warm-up/run sequencer streaming chaotic map words
module chaos_keystream_ctrl
    import chaos_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          WARMUP       = 64,
    parameter logic [15:0] DEFAULT_SEED = chaos_pkg::DEFAULT_SEED,
    parameter logic [15:0] PERTURB      = PERTURB_DEFAULT,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             stuck_evt,
    output logic [CNT_W-1:0] stuck_cnt
);

    localparam int            WC         = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WC-1:0] WARMUP_CNT = WC'(WARMUP);

    state_t           state, next_state;
    logic [WIDTH-1:0] x, x_prev, x_next, x_adv;
    logic [WC-1:0]    cnt;
    logic             deg;
    logic             load_seed, load_cnt, warm_adv, first_word, xfer, adv;

    quadratic_step u_step (
        .x      (x),
        .x_next (x_next)
    );

    // a fixed point or a 2-cycle is broken by folding the perturbation mask into the next state
    assign deg   = (x_next == x) || (x_next == x_prev);
    assign x_adv = deg ? (x_next ^ PERTURB) : x_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (seed_valid || start) begin
                    next_state = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (cnt == '0) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        seed_ready = 1'b0;
        load_seed  = 1'b0;
        load_cnt   = 1'b0;
        warm_adv   = 1'b0;
        first_word = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_IDLE: begin
                seed_ready = 1'b1;
                load_seed  = seed_valid;
                load_cnt   = seed_valid || start;
            end
            ST_WARMUP: begin
                warm_adv   = !stop && (cnt != '0);
                first_word = !stop && (cnt == '0);
            end
            ST_RUN: begin
                // a transfer in the same cycle as stop still completes
                xfer = out_valid && out_ready;
            end
            default: ;
        endcase
        adv = warm_adv || xfer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= DEFAULT_SEED;
            x_prev    <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            stuck_evt <= 1'b0;
            stuck_cnt <= '0;
        end else begin
            out_valid <= (next_state == ST_RUN);
            busy      <= (next_state != ST_IDLE);
            stuck_evt <= adv && deg;

            if (load_seed) begin
                x      <= seed;
                x_prev <= ~seed;
            end else if (adv) begin
                x_prev <= x;
                x      <= x_adv;
            end

            if (load_cnt) begin
                cnt <= WARMUP_CNT;
            end else if (warm_adv) begin
                cnt <= cnt - 1'b1;
            end

            if (first_word) begin
                out_data <= x;
            end else if (xfer) begin
                out_data <= x_adv;
            end

            if (adv && deg && (stuck_cnt != '1)) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
        end
    end

endmodule
